// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer / direction predictor.
package btb_pkg;

    localparam logic [6:0] BR_OP = 7'b1100011;

    // Direction counter encodings for the default 2-bit counter.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/btb_bht_sat_cnt.sv
// Saturating up/down next-value function for one direction counter.
module bp_sat_cnt #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         up,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (up && (cnt != '1))
            nxt = cnt + W'(1);
        else if (!up && (cnt != '0))
            nxt = cnt - W'(1);
    end

endmodule

// File: rtl/btb_bht.sv
// Set-associative BTB with per-entry saturating direction counters.
// Lookup on PCF is combinational; training from the EX stage on the rising edge.
module btb_bht
    import btb_pkg::*;
#(
    parameter int ENTRY_NUM = 64,
    parameter int WAYS      = 2,
    parameter int CNT_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic [31:0] PCE,
    input  logic        BrInstrE,
    input  logic        BranchE,
    input  logic [31:0] BrNPC,
    input  logic        PredictedE,
    input  logic [31:0] PredTargetE,
    output logic [31:0] PredictedPC,
    output logic        PredictedF,
    output logic        MispredE,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
);

    localparam int SETS = ENTRY_NUM / WAYS;
    localparam int IDX  = clog2(SETS);
    localparam int TAGW = 30 - IDX;
    localparam int WB   = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_WT = CNT_BITS'(1) << (CNT_BITS - 1);

    if (((ENTRY_NUM & (ENTRY_NUM - 1)) != 0) || (ENTRY_NUM < 2 * WAYS)) begin : gBadEntryNum
        $error("btb_bht: ENTRY_NUM must be a power of two and at least 2*WAYS");
    end
    if (!((WAYS == 1) || (WAYS == 2) || (WAYS == 4))) begin : gBadWays
        $error("btb_bht: WAYS must be 1, 2 or 4");
    end
    if (CNT_BITS < 1) begin : gBadCntBits
        $error("btb_bht: CNT_BITS must be at least 1");
    end

    logic [SETS-1:0][WAYS-1:0]                validArr;
    logic [SETS-1:0][WAYS-1:0][TAGW-1:0]      tagArr;
    logic [SETS-1:0][WAYS-1:0][31:0]          targetArr;
    logic [SETS-1:0][WAYS-1:0][CNT_BITS-1:0]  cntArr;
    logic [SETS-1:0][WB-1:0]                  rrArr;

    logic [IDX-1:0]  setF, setE;
    logic [TAGW-1:0] tagF, tagE;
    logic            unusedPcBits;

    assign setF = PCF[IDX+1:2];
    assign tagF = PCF[31:IDX+2];
    assign setE = PCE[IDX+1:2];
    assign tagE = PCE[31:IDX+2];
    assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup: allocation only on a miss keeps matches one-hot.
    logic                hitF;
    logic [31:0]         hitTgtF;
    logic [CNT_BITS-1:0] hitCntF;

    always_comb begin
        hitF    = 1'b0;
        hitTgtF = '0;
        hitCntF = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[setF][w] && (tagArr[setF][w] == tagF)) begin
                hitF    = 1'b1;
                hitTgtF = targetArr[setF][w];
                hitCntF = cntArr[setF][w];
            end
        end
    end

    assign PredictedF  = hitF & hitCntF[CNT_BITS-1];
    assign PredictedPC = PredictedF ? hitTgtF : PCF + 32'd4;
    assign MispredE    = BrInstrE & ((PredictedE != BranchE) |
                                     (BranchE & PredictedE & (PredTargetE != BrNPC)));

    // EX-side lookup plus victim choice; descending scan makes the lowest invalid way win.
    logic          hitE, invFound;
    logic [WB-1:0] hitWayE, invWay, allocWay;

    always_comb begin
        hitE     = 1'b0;
        hitWayE  = '0;
        invFound = 1'b0;
        invWay   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validArr[setE][w] && (tagArr[setE][w] == tagE)) begin
                hitE    = 1'b1;
                hitWayE = WB'(w);
            end
            if (!validArr[setE][w]) begin
                invFound = 1'b1;
                invWay   = WB'(w);
            end
        end
    end

    assign allocWay = invFound ? invWay : rrArr[setE];

    logic [CNT_BITS-1:0] cntNxtE;

    bp_sat_cnt #(.W(CNT_BITS)) uSatCnt (
        .cnt (cntArr[setE][hitWayE]),
        .up  (BranchE),
        .nxt (cntNxtE)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            validArr  <= '0;
            cntArr    <= '0;
            rrArr     <= '0;
            BrCount   <= '0;
            MissCount <= '0;
        end else if (BrInstrE) begin
            BrCount <= BrCount + 32'd1;
            if (MispredE)
                MissCount <= MissCount + 32'd1;
            if (hitE) begin
                cntArr[setE][hitWayE] <= cntNxtE;
            end else if (BranchE) begin
                validArr[setE][allocWay] <= 1'b1;
                cntArr[setE][allocWay]   <= CNT_WT;
                if (!invFound && (WAYS > 1))
                    rrArr[setE] <= rrArr[setE] + WB'(1);
            end
        end
    end

    // Tag/target storage carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (!rst && BrInstrE && BranchE) begin
            if (hitE) begin
                targetArr[setE][hitWayE] <= BrNPC;
            end else begin
                tagArr[setE][allocWay]    <= tagE;
                targetArr[setE][allocWay] <= BrNPC;
            end
        end
    end

endmodule

// File: tb/tb_btb_bht.sv
// Randomized scoreboard bench for btb_bht against a per-set reference model.
module tb_btb_bht;

    localparam int ENTRY_NUM = 64;
    localparam int WAYS      = 2;
    localparam int CNT_BITS  = 2;
    localparam int SETS      = ENTRY_NUM / WAYS;
    localparam int IDX       = $clog2(SETS);
    localparam int CMAX      = (1 << CNT_BITS) - 1;
    localparam int CMSB      = 1 << (CNT_BITS - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, BrNPC, PredTargetE, PredictedPC, BrCount, MissCount;
    logic        BrInstrE, BranchE, PredictedE, PredictedF, MispredE;

    btb_bht #(.ENTRY_NUM(ENTRY_NUM), .WAYS(WAYS), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PCE(PCE), .BrInstrE(BrInstrE),
        .BranchE(BranchE), .BrNPC(BrNPC), .PredictedE(PredictedE),
        .PredTargetE(PredTargetE), .PredictedPC(PredictedPC),
        .PredictedF(PredictedF), .MispredE(MispredE), .BrCount(BrCount),
        .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic        predF;
        logic [31:0] predPC;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] mc;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: each set is a small list of (valid, tag, target, counter) entries.
    bit          mVal[SETS][WAYS];
    logic [31:0] mTag[SETS][WAYS];
    logic [31:0] mTgt[SETS][WAYS];
    int          mCnt[SETS][WAYS];
    int          mRr[SETS];
    logic [31:0] mBc, mMc;
    bit          known = 0;

    function automatic int setOf(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic void look(input logic [31:0] pc, output bit h, output int w);
        int s;
        s = setOf(pc);
        h = 0;
        w = 0;
        for (int i = 0; i < WAYS; i++)
            if (mVal[s][i] && (mTag[s][i] == (pc >> (IDX + 2)))) begin
                h = 1;
                w = i;
            end
    endfunction

    function automatic bit mPredF(input logic [31:0] pc);
        bit h;
        int w;
        look(pc, h, w);
        return h && (mCnt[setOf(pc)][w] >= CMSB);
    endfunction

    function automatic logic [31:0] mPredPC(input logic [31:0] pc);
        bit h;
        int w;
        look(pc, h, w);
        if (h && (mCnt[setOf(pc)][w] >= CMSB)) return mTgt[setOf(pc)][w];
        return pc + 32'd4;
    endfunction

    function automatic void mUpdate(input logic r, input logic bi, input logic [31:0] pce,
                                    input logic bt, input logic [31:0] npc, input bit mis);
        bit h;
        int w, s, v;
        if (r) begin
            for (int i = 0; i < SETS; i++) begin
                mRr[i] = 0;
                for (int j = 0; j < WAYS; j++) begin
                    mVal[i][j] = 0;
                    mCnt[i][j] = 0;
                end
            end
            mBc = 0;
            mMc = 0;
            known = 1;
            return;
        end
        if (!bi || !known) return;
        mBc = mBc + 1;
        if (mis) mMc = mMc + 1;
        s = setOf(pce);
        look(pce, h, w);
        if (h) begin
            if (bt) begin
                mCnt[s][w] = (mCnt[s][w] < CMAX) ? mCnt[s][w] + 1 : CMAX;
                mTgt[s][w] = npc;
            end else begin
                mCnt[s][w] = (mCnt[s][w] > 0) ? mCnt[s][w] - 1 : 0;
            end
        end else if (bt) begin
            v = -1;
            for (int i = WAYS - 1; i >= 0; i--)
                if (!mVal[s][i]) v = i;
            if (v < 0) begin
                v = mRr[s];
                mRr[s] = (mRr[s] + 1) % WAYS;
            end
            mVal[s][v] = 1;
            mTag[s][v] = pce >> (IDX + 2);
            mTgt[s][v] = npc;
            mCnt[s][v] = CMSB;
        end
    endfunction

    task automatic cyc(input logic r, input logic [31:0] pcf, input logic bi,
                       input logic [31:0] pce, input logic bt, input logic [31:0] npc,
                       input logic pe, input logic [31:0] pt, input string nm);
        exp_t e;
        rst = r; PCF = pcf; BrInstrE = bi; PCE = pce; BranchE = bt;
        BrNPC = npc; PredictedE = pe; PredTargetE = pt;
        e.chk    = known;
        e.predF  = mPredF(pcf);
        e.predPC = mPredPC(pcf);
        e.mis    = bi && ((pe != bt) || (bt && pe && (pt != npc)));
        e.bc     = mBc;
        e.mc     = mMc;
        e.nm     = nm;
        q.push_back(e);
        @(posedge clk);
        mUpdate(r, bi, pce, bt, npc, e.mis);
        #1;
    endtask

    task automatic idle(input logic [31:0] pcf, input string nm);
        cyc(1'b0, pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, nm);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp({e.nm, ".PredictedF"},  {31'b0, PredictedF}, {31'b0, e.predF});
                    cmp({e.nm, ".PredictedPC"}, PredictedPC, e.predPC);
                    cmp({e.nm, ".MispredE"},    {31'b0, MispredE}, {31'b0, e.mis});
                    cmp({e.nm, ".BrCount"},     BrCount, e.bc);
                    cmp({e.nm, ".MissCount"},   MissCount, e.mc);
                end
            end
        end
    end

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin : stim
        logic [31:0] pce, pt, npc;
        logic        pe, bi, bt, r;
        int          wait_cnt;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h100, 1'b0, 0, 0, 0, 0, 0, "reset0");
        cyc(1'b1, 32'h100, 1'b0, 0, 0, 0, 0, 0, "reset1");
        idle(32'h100, "afterReset");
        // first taken branch allocates weakly-taken
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, "allocMiss");
        idle(32'h100, "allocHit");
        // walk the counter down then back up to saturation
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, "nt1");
        idle(32'h100, "nt1Fetch");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, "nt2");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, "nt3");
        idle(32'h100, "nt3Fetch");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, "t1");
        idle(32'h100, "t1Fetch");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, "t2");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, "t3");
        idle(32'h100, "t3Fetch");
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, "tgtChange");
        idle(32'h100, "tgtNew");
        // three taken branches to one set: third evicts way 0
        cyc(1'b1, 32'h0, 1'b0, 0, 0, 0, 0, 0, "reset2");
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h1100, 1'b0, 32'h0, "ev100");
        cyc(1'b0, 32'h0, 1'b1, 32'h180, 1'b1, 32'h1180, 1'b0, 32'h0, "ev180");
        cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h1200, 1'b0, 32'h0, "ev200");
        idle(32'h100, "ev100Look");
        idle(32'h180, "ev180Look");
        idle(32'h200, "ev200Look");
        // reset beats a simultaneous allocation
        cyc(1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 32'h800, 1'b0, 32'h0, "rstAlloc");
        idle(32'h400, "rstAllocLook");
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            bi  = ($urandom_range(0, 3) != 0);
            bt  = $urandom_range(0, 1);
            pce = rpc();
            npc = (32'($urandom_range(0, 3)) << 4) | 32'h4000;
            if ($urandom_range(0, 1) == 1) begin
                pe = mPredF(pce);
                pt = mPredPC(pce);
            end else begin
                pe = $urandom_range(0, 1);
                pt = (32'($urandom_range(0, 3)) << 4) | 32'h4000;
            end
            cyc(r, rpc(), bi, pce, bt, npc, pe, pt, "rand");
        end
        idle(32'h0, "drain");
        wait_cnt = 0;
        while ((q.size() > 0) && (wait_cnt < 10)) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
